// File: rtl/score_display_scanner_pkg.sv
// score_disp_pkg: shared constants, types and helpers for the score display scanner.
package score_disp_pkg;

  // Nibble value that drives a blank digit on the downstream 7-segment decoder.
  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef logic [3:0] bcd_t;

  // Index width for a count of n items; never narrower than one bit.
  function automatic int unsigned team_idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/score_display_scanner_digit_scan_counter.sv
// digit_scan_counter: prescaler plus digit index for the display scan.
// Emits the current digit index, a prescaler-wrap strobe and a frame-boundary strobe.
module digit_scan_counter
  import score_disp_pkg::*;
#(
  parameter int unsigned DIGITS   = 2,
  parameter int unsigned SCAN_DIV = 4,
  localparam int unsigned IW = team_idx_w(DIGITS)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  output logic [IW-1:0] o_digit_idx,
  output logic          o_wrap,
  output logic          o_frame
);

  localparam int unsigned PW = team_idx_w(SCAN_DIV);

  logic          r_run;
  logic [PW-1:0] r_pres;
  logic [IW-1:0] r_idx;
  logic          w_wrap;
  logic          w_last;

  // The prescaler holds for the first edge out of reset so that the first
  // displayed digit, like every later one, is held a full SCAN_DIV cycles.
  always_comb begin
    w_wrap = r_run && (r_pres == PW'(SCAN_DIV - 1));
    w_last = (r_idx == IW'(DIGITS - 1));
  end

  assign o_digit_idx = r_idx;
  assign o_wrap      = w_wrap;
  assign o_frame     = w_wrap && w_last;

  // Prescaler and digit index advance.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_run  <= 1'b0;
      r_pres <= '0;
      r_idx  <= '0;
    end else begin
      r_run <= 1'b1;
      if (r_run) begin
        r_pres <= w_wrap ? '0 : r_pres + 1'b1;
      end
      if (w_wrap) begin
        r_idx <= w_last ? '0 : r_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/score_display_scanner.sv
// score_display_scanner: per-team BCD score storage scanned one digit at a
// time onto a shared nibble bus with an active-low one-hot digit enable.
// Optional feature macro: SCORE_AUTO_ROTATE_EN (auto team rotation every
// ROTATE_FRAMES frames; sel_team ignored). Default build is manual select.
module score_display_scanner
  import score_disp_pkg::*;
#(
  parameter int unsigned TEAMS         = 2,
  parameter int unsigned DIGITS        = 2,
  parameter int unsigned SCAN_DIV      = 4,
  parameter int unsigned ROTATE_FRAMES = 8,
  localparam int unsigned TW = team_idx_w(TEAMS),
  localparam int unsigned IW = team_idx_w(DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [TW-1:0]         sel_team,
  input  logic                  load,
  input  logic [TW-1:0]         load_team,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [3:0]            digit_code,
  output logic [DIGITS-1:0]     digit_en,
  output logic [TW-1:0]         team_out,
  output logic                  frame_done
);

  if (TEAMS < 2 || DIGITS < 1 || SCAN_DIV < 1 || ROTATE_FRAMES < 1) begin : g_param_check
    $error("score_display_scanner: illegal parameter value");
  end

  logic [4*DIGITS-1:0] r_score [TEAMS];
  logic [TW-1:0]       r_team;
  bcd_t                r_code;
  logic [DIGITS-1:0]   r_en;
  logic                r_frame_done;

  logic [IW-1:0]       w_idx;
  logic [IW-1:0]       w_idx_nxt;
  logic                w_wrap;
  logic                w_frame;
  logic [TW-1:0]       w_team_nxt;
  logic                w_load_ok;
  logic [4*DIGITS-1:0] w_disp_score;
  bcd_t                w_code_nxt;
  logic [DIGITS-1:0]   w_en_nxt;

  digit_scan_counter #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .i_clk       (clk),
    .i_rst       (rst),
    .o_digit_idx (w_idx),
    .o_wrap      (w_wrap),
    .o_frame     (w_frame)
  );

  // Digit index after this edge; outputs are registered from next state.
  always_comb begin
    w_idx_nxt = w_idx;
    if (w_wrap) begin
      w_idx_nxt = (w_idx == IW'(DIGITS - 1)) ? '0 : w_idx + 1'b1;
    end
  end

`ifdef SCORE_AUTO_ROTATE_EN
  localparam int unsigned FW = team_idx_w(ROTATE_FRAMES);

  logic [FW-1:0] r_fcnt;
  logic          w_rot;
  logic          w_unused_sel;

  assign w_unused_sel = ^sel_team;

  // Team advances when the frame counter wraps on a frame boundary.
  always_comb begin
    w_rot      = w_frame && (r_fcnt == FW'(ROTATE_FRAMES - 1));
    w_team_nxt = r_team;
    if (w_rot) begin
      w_team_nxt = (r_team == TW'(TEAMS - 1)) ? '0 : r_team + 1'b1;
    end
  end

  // Frame counter, stepped once per frame boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fcnt <= '0;
    end else if (w_frame) begin
      r_fcnt <= w_rot ? '0 : r_fcnt + 1'b1;
    end
  end
`else
  // Manual select takes effect only at a frame boundary and only if in range.
  always_comb begin
    w_team_nxt = r_team;
    if (w_frame && (32'(sel_team) < TEAMS)) begin
      w_team_nxt = sel_team;
    end
  end
`endif

  // Bypass a same-edge write so a load shows on the display one cycle later.
  always_comb begin
    w_load_ok    = load && (32'(load_team) < TEAMS);
    w_disp_score = r_score[w_team_nxt];
    if (w_load_ok && (load_team == w_team_nxt)) begin
      w_disp_score = load_value;
    end
    w_code_nxt = w_disp_score[4*w_idx_nxt +: 4];
    w_en_nxt   = '1;
    w_en_nxt[w_idx_nxt] = 1'b0;
  end

  // Score register file; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned t = 0; t < TEAMS; t++) begin
        r_score[t] <= '0;
      end
    end else if (w_load_ok) begin
      r_score[load_team] <= load_value;
    end
  end

  // Displayed team and registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_team       <= '0;
      r_code       <= BCD_BLANK;
      r_en         <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_team       <= w_team_nxt;
      r_code       <= w_code_nxt;
      r_en         <= w_en_nxt;
      r_frame_done <= w_frame;
    end
  end

  assign digit_code = r_code;
  assign digit_en   = r_en;
  assign team_out   = r_team;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_score_display_scanner.sv
// Scoreboard bench for score_display_scanner (TEAMS=3, DIGITS=2, SCAN_DIV=4).
// Reference model works from the cycle count since reset rather than counters.
module tb_score_display_scanner;

  localparam int TEAMS    = 3;
  localparam int DIGITS   = 2;
  localparam int SCAN_DIV = 4;
  localparam int ROT      = 2;
  localparam int TW       = 2;
  localparam int FRAME    = SCAN_DIV * DIGITS;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [TW-1:0]       sel_team = '0;
  logic                load = 1'b0;
  logic [TW-1:0]       load_team = '0;
  logic [4*DIGITS-1:0] load_value = '0;
  logic [3:0]          digit_code;
  logic [DIGITS-1:0]   digit_en;
  logic [TW-1:0]       team_out;
  logic                frame_done;

  score_display_scanner #(
    .TEAMS         (TEAMS),
    .DIGITS        (DIGITS),
    .SCAN_DIV      (SCAN_DIV),
    .ROTATE_FRAMES (ROT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sel_team   (sel_team),
    .load       (load),
    .load_team  (load_team),
    .load_value (load_value),
    .digit_code (digit_code),
    .digit_en   (digit_en),
    .team_out   (team_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]        code;
    logic [DIGITS-1:0] en;
    logic [TW-1:0]     team;
    logic              fd;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;

  int                  m_t    = 0;
  int                  m_team = 0;
  int                  m_fcnt = 0;
  logic [4*DIGITS-1:0] m_score [TEAMS];

  // Drive one cycle of inputs and push what the next edge must produce.
  task automatic cyc(input logic r, input int sel, input logic ld, input int lt,
                     input logic [4*DIGITS-1:0] lv);
    exp_t e;
    int   idx;
    @(negedge clk);
    rst        = r;
    sel_team   = TW'(sel);
    load       = ld;
    load_team  = TW'(lt);
    load_value = lv;
    if (r) begin
      e.code = 4'hF; e.en = '1; e.team = '0; e.fd = 1'b0;
      m_t = 0; m_team = 0; m_fcnt = 0;
      for (int i = 0; i < TEAMS; i++) m_score[i] = '0;
    end else begin
      if (ld && lt < TEAMS) m_score[lt] = lv;
      e.fd = (m_t > 0) && (m_t % FRAME == 0);
      if (e.fd) begin
`ifdef SCORE_AUTO_ROTATE_EN
        m_fcnt = m_fcnt + 1;
        if (m_fcnt == ROT) begin
          m_fcnt = 0;
          m_team = (m_team + 1) % TEAMS;
        end
`else
        if (sel < TEAMS) m_team = sel;
`endif
      end
      idx = (m_t / SCAN_DIV) % DIGITS;
      e.code = m_score[m_team][4*idx +: 4];
      e.en = '1;
      e.en[idx] = 1'b0;
      e.team = TW'(m_team);
      m_t++;
    end
    q.push_back(e);
  endtask

  task automatic idle(input int n, input int sel);
    for (int i = 0; i < n; i++) cyc(1'b0, sel, 1'b0, 0, '0);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, expv);
    end
  endtask

  // Sample after the edge once the design has presented its registered outputs.
  task automatic sample();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every edge that has a pending expectation is compared.
  always begin
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      n_chk++;
      if ({digit_code, digit_en, team_out, frame_done} !== mon_e) begin
        n_fail++;
        $display("FAIL scoreboard @%0t: got code=%h en=%b team=%0d fd=%b, expected code=%h en=%b team=%0d fd=%b",
                 $time, digit_code, digit_en, team_out, frame_done,
                 mon_e.code, mon_e.en, mon_e.team, mon_e.fd);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    for (int i = 0; i < TEAMS; i++) m_score[i] = '0;

    cyc(1'b1, 0, 1'b0, 0, '0);
    cyc(1'b1, 0, 1'b0, 0, '0);
    sample();
    chk("rst_code", 32'(digit_code), 32'hF);
    chk("rst_en", 32'(digit_en), 32'b11);
    chk("rst_team", 32'(team_out), 0);
    chk("rst_fd", 32'(frame_done), 0);

    idle(1, 0);
    sample();
    chk("first_en", 32'(digit_en), 32'b10);
    chk("first_code", 32'(digit_code), 0);
    idle(23, 0);

    cyc(1'b0, 1, 1'b1, 1, 8'h37);
    cyc(1'b0, 1, 1'b1, 0, 8'h52);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc(1'b0, 1, 1'b0, 0, '0);
      sample();
      seen = frame_done;
    end
    chk("fd_seen_sel1", 32'(seen), 1);
`ifndef SCORE_AUTO_ROTATE_EN
    chk("sel1_team", 32'(team_out), 1);
    chk("sel1_digit0", 32'(digit_code), 7);
`endif
    idle(4, 1);
    sample();
    chk("sel1_en_digit1", 32'(digit_en), 32'b01);
`ifndef SCORE_AUTO_ROTATE_EN
    chk("sel1_digit1", 32'(digit_code), 3);
`endif

    // sel_team changes mid-frame; team must hold until the boundary
    idle(3, 0);
    sample();
`ifndef SCORE_AUTO_ROTATE_EN
    chk("midframe_team_held", 32'(team_out), 1);
`endif
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc(1'b0, 0, 1'b0, 0, '0);
      sample();
      seen = frame_done;
    end
    chk("fd_seen_sel0", 32'(seen), 1);
`ifndef SCORE_AUTO_ROTATE_EN
    chk("sel0_team", 32'(team_out), 0);
    chk("sel0_digit0", 32'(digit_code), 2);
`endif

    // Out-of-range select and write
    for (int i = 0; i < 20; i++) cyc(1'b0, 3, 1'b1, 3, 8'h99);
    sample();
`ifndef SCORE_AUTO_ROTATE_EN
    chk("oor_team_held", 32'(team_out), 0);
`endif

    // Load to the displayed team mid-frame, then raw non-BCD nibbles
    idle(2, 0);
    cyc(1'b0, 0, 1'b1, 0, 8'h61);
    idle(5, 0);
    cyc(1'b0, 2, 1'b1, 2, 8'hAB);
    idle(19, 2);

    // Reset mid-digit with scores loaded
    idle(2, 2);
    cyc(1'b1, 2, 1'b0, 0, '0);
    sample();
    chk("midrst_code", 32'(digit_code), 32'hF);
    chk("midrst_en", 32'(digit_en), 32'b11);
    chk("midrst_team", 32'(team_out), 0);
    idle(17, 1);
    idle(16, 2);
    idle(16, 0);
`ifdef SCORE_AUTO_ROTATE_EN
    idle(50, 1);
`endif

    idle(2, 0);
    @(posedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/score_display_scanner.md
# score_display_scanner

Time-multiplexed scoreboard display driver: holds a BCD score register per team and scans the selected team's digits onto one shared 4-bit digit bus with a one-hot, active-low digit enable. Parametrised successor of the fixed two-team constant-pattern selector, generalised in team count, digit count and scan rate. It adds registered score storage, a digit scan counter and frame-aligned team switching. Sits between the scoring logic and the 7-segment decoder/anode drivers.

## Interface

- TEAMS, 2, number of teams (≥2)
- DIGITS, 2, BCD digits per score (≥1)
- SCAN_DIV, 4, clock cycles each digit is held (≥1)
- ROTATE_FRAMES, 8, full frames per team in auto-rotate mode (≥1)
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- sel_team  in  $clog2(TEAMS)  manual team select, sampled at frame boundary
- load  in  1  write strobe for score register
- load_team  in  $clog2(TEAMS)  team index written by load
- load_value  in  4*DIGITS  BCD score; nibble k = digit k, digit 0 least significant
- digit_code  out  4  BCD nibble currently displayed; 4'hF = blank
- digit_en  out  DIGITS  active-low one-hot digit enable
- team_out  out  $clog2(TEAMS)  team currently displayed
- frame_done  out  1  one-cycle pulse at end of each frame

## Operation

- Score registers: TEAMS × 4*DIGITS bits, all reset to 0. When load=1 and load_team<TEAMS, the addressed register takes load_value at the clock edge. When load_team≥TEAMS, the write is dropped. Nibbles >9 are stored unchanged and displayed raw.
- Prescaler counts 0..SCAN_DIV-1 and wraps. On wrap, digit index advances 0..DIGITS-1 and wraps to 0.
- Frame boundary = prescaler wrap while digit index = DIGITS-1. That cycle asserts frame_done and performs any team update, so the team changes only between frames (no mixed-team frames).
- Manual mode: at a frame boundary, team ← sel_team if sel_team<TEAMS; otherwise team is held.
- Outputs are registered from the next state. digit_en[digit index]=0 and all other bits are 1. digit_code = score[team][4*idx +: 4].
- A load to the displayed team is visible on digit_code the cycle after the write edge, mid-frame included.
- Reset mid-operation: all counters, team and scores clear on the next edge. Outputs return to reset values the same edge.

## Timing

- Reset values: digit_code=4'hF, digit_en=all ones, team_out=0, frame_done=0, prescaler=0, digit index=0, frame counter=0.
- First edge after rst deasserts: digit_en shows digit 0 and digit_code shows score[0] digit 0.
- Each digit is held exactly SCAN_DIV cycles; a frame is SCAN_DIV*DIGITS cycles.
- frame_done is high for exactly the first cycle of each new frame, i.e. registered together with the wrap to digit 0 and the new team.
- Output latency from internal state is 1 cycle. Latency from load to display is 1 cycle.
- SCAN_DIV=1: digit advances every cycle. DIGITS=1: every prescaler wrap is a frame boundary.

## Configuration

- SCORE_AUTO_ROTATE_EN defined: sel_team is ignored. A frame counter 0..ROTATE_FRAMES-1 increments at each frame boundary. On its wrap, team ← (team+1) mod TEAMS. The counter is cleared by rst.
- Not defined: manual mode as above, with no frame counter logic.

## Structure

- Package score_disp_pkg:
  - BCD_BLANK = 4'hF
  - typedef for a BCD nibble
  - function for the team index width (minimum 1 bit)
- One sub-module: digit_scan_counter. It contains the prescaler and digit index, and outputs the digit index, a wrap strobe and a frame-boundary strobe.
- The top level holds the score registers, team/rotate logic and output registers.

## Test plan

- Reset, then run TEAMS=2, DIGITS=2, SCAN_DIV=4 with no load -> digit_en sequence 2'b10 ×4, 2'b01 ×4, repeating. digit_code=0 throughout. frame_done high every 8th cycle.
- Load team 1 = 8'h37 and team 0 = 8'h52, sel_team=1 -> after the next frame_done, digit_code shows 7 (digit 0) then 3 (digit 1) with team_out=1.
- Change sel_team mid-frame -> team_out and digit_code keep the old team until the frame_done cycle.
- Use sel_team=3 with TEAMS=3, or load_team out of range -> team is held and no score register changes.
- Assert rst for one cycle mid-digit with scores loaded -> next cycle has digit_code=4'hF, digit_en all ones and team_out=0. All scores read back 0.
- With SCORE_AUTO_ROTATE_EN and ROTATE_FRAMES=2, TEAMS=3 -> team_out advances 0→1→2→0 every 2 frames (16 cycles).
